// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter between the instruction-fetch (I) and
// data (D) requesters for the shared byte-wide RAM/ROM/IO bus. Each transaction
// is sequenced IDLE -> ACCESS -> (WAIT)* -> DONE -> IDLE.
// Optional feature: define MEM_ARB_LOCK_EN to add i_lock/d_lock, which pin the
// grant to the last winner so multi-byte bursts stay atomic.
module mem_bus_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              bus_use,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ARB_LOCK_EN
   ,
   input  logic              i_lock,
   input  logic              d_lock
`endif
);

   // Remaining read-strobe cycles after ACCESS; 3 bits covers READ_LAT 1..7.
   localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;
   typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

   state_t     state, state_nxt;
   side_t      owner, last_gnt, winner;
   logic       wr_q, wr_nxt;
   logic [2:0] cnt;
   logic       any_req;
   logic       bus_use_nxt, bus_read_nxt, bus_write_nxt;
`ifdef MEM_ARB_LOCK_EN
   logic       pinned;
   side_t      pin_side;
`endif

   // Arbitration: a lone request wins; on a tie the side not served last wins.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      winner  = SIDE_I;
      any_req = i_req || d_req;
      if (i_req && d_req)
         winner = (last_gnt == SIDE_I) ? SIDE_D : SIDE_I;
      else if (d_req)
         winner = SIDE_D;
`ifdef MEM_ARB_LOCK_EN
      // A pinned grant only accepts the pinned side; the other side keeps waiting.
      if (pinned) begin
         winner  = pin_side;
         any_req = (pin_side == SIDE_I) ? i_req : d_req;
      end
`endif
   end

   // Next-state logic and the next values of the registered bus strobes.
   always_comb begin
      state_nxt = state;
      wr_nxt    = wr_q;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_nxt = ST_ACCESS;
               wr_nxt    = (winner == SIDE_D) && d_write;
            end
         end
         ST_ACCESS: begin
            if (wr_q || (LAT_M1 == 3'd0)) state_nxt = ST_DONE;
            else                          state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == 3'd1) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      bus_use_nxt   = (state_nxt == ST_ACCESS) || (state_nxt == ST_WAIT);
      bus_read_nxt  = bus_use_nxt && !wr_nxt;
      bus_write_nxt = (state_nxt == ST_ACCESS) && wr_nxt;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Datapath: request capture, registered bus outputs, latency count, completion.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: every register here is reset, so an abort mid-transaction drops
      // the strobes at once and leaves no stale done pulse or read data behind.
      if (!reset_n) begin
         owner     <= SIDE_I;
         last_gnt  <= SIDE_I;
         wr_q      <= 1'b0;
         cnt       <= '0;
         bus_use   <= 1'b0;
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
`ifdef MEM_ARB_LOCK_EN
         pinned    <= 1'b0;
         pin_side  <= SIDE_I;
`endif
      end else begin
         bus_use   <= bus_use_nxt;
         bus_read  <= bus_read_nxt;
         bus_write <= bus_write_nxt;
         wr_q      <= wr_nxt;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner    <= winner;
                  bus_addr <= (winner == SIDE_D) ? d_addr : i_addr;
                  if (winner == SIDE_D) bus_wdata <= d_wdata;
               end
            end
            ST_ACCESS: begin
               cnt <= LAT_M1;
               // Writes carry no return data, so they report completion on entry to DONE.
               if (wr_q) d_done <= 1'b1;
            end
            ST_WAIT: cnt <= cnt - 3'd1;
            ST_DONE: begin
               last_gnt <= owner;
               // Read data is valid on the bus during DONE; capture and pulse together.
               if (!wr_q) begin
                  if (owner == SIDE_I) begin
                     i_rdata <= bus_rdata;
                     i_done  <= 1'b1;
                  end else begin
                     d_rdata <= bus_rdata;
                     d_done  <= 1'b1;
                  end
               end
`ifdef MEM_ARB_LOCK_EN
               pinned   <= (owner == SIDE_I) ? i_lock : d_lock;
               pin_side <= owner;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed, self-checking bench for mem_bus_arbiter.
// Two instances share stimulus: dut_a uses READ_LAT=1 and dut_b READ_LAT=3; each
// has its own behavioural memory. A scoreboard queue holds the expected completions.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_req = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [7:0]  d_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
   logic        i_lock = 1'b0;
   logic        d_lock = 1'b0;
`endif

   logic        a_i_done, a_d_done, a_bus_use, a_bus_read, a_bus_write;
   logic [7:0]  a_i_rdata, a_d_rdata, a_bus_wdata, a_bus_rdata;
   logic [31:0] a_bus_addr;
   logic        b_i_done, b_d_done, b_bus_use, b_bus_read, b_bus_write;
   logic [7:0]  b_i_rdata, b_d_rdata, b_bus_wdata, b_bus_rdata;
   logic [31:0] b_bus_addr;

   logic        sel = 1'b0;
   logic        m_i_done, m_d_done, m_bus_use, m_bus_read, m_bus_write;
   logic [7:0]  m_i_rdata, m_d_rdata, m_bus_wdata;
   logic [31:0] m_bus_addr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       side;      // 0 = I, 1 = D
      logic       is_write;
      logic [7:0] rdata;
      logic [7:0] lat;       // cycles from request to done
      logic       drop;      // drop the request when this completion is seen
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .READ_LAT(1)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(a_i_done), .i_rdata(a_i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(a_d_done), .d_rdata(a_d_rdata),
      .bus_use(a_bus_use), .bus_addr(a_bus_addr), .bus_read(a_bus_read),
      .bus_write(a_bus_write), .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata)
`ifdef MEM_ARB_LOCK_EN
      , .i_lock(i_lock), .d_lock(d_lock)
`endif
   );

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .READ_LAT(3)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(b_i_done), .i_rdata(b_i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(b_d_done), .d_rdata(b_d_rdata),
      .bus_use(b_bus_use), .bus_addr(b_bus_addr), .bus_read(b_bus_read),
      .bus_write(b_bus_write), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata)
`ifdef MEM_ARB_LOCK_EN
      , .i_lock(i_lock), .d_lock(d_lock)
`endif
   );

   // Memory contents: each byte is its low address byte plus 0x20.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] + 8'h20;
   endfunction

   // Memory models: data appears READ_LAT cycles after a read strobe, 0xEE otherwise.
   logic [7:0] a_pipe = 8'hEE;
   logic [7:0] b_pipe [3] = '{8'hEE, 8'hEE, 8'hEE};
   always @(posedge clk) begin
      a_pipe    <= a_bus_read ? mem_byte(a_bus_addr) : 8'hEE;
      b_pipe[0] <= b_bus_read ? mem_byte(b_bus_addr) : 8'hEE;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign a_bus_rdata = a_pipe;
   assign b_bus_rdata = b_pipe[2];

   // Route the instance under observation to the monitor signals.
   always_comb begin
      m_i_done    = sel ? b_i_done    : a_i_done;
      m_d_done    = sel ? b_d_done    : a_d_done;
      m_i_rdata   = sel ? b_i_rdata   : a_i_rdata;
      m_d_rdata   = sel ? b_d_rdata   : a_d_rdata;
      m_bus_use   = sel ? b_bus_use   : a_bus_use;
      m_bus_read  = sel ? b_bus_read  : a_bus_read;
      m_bus_write = sel ? b_bus_write : a_bus_write;
      m_bus_wdata = sel ? b_bus_wdata : a_bus_wdata;
      m_bus_addr  = sel ? b_bus_addr  : a_bus_addr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_txn(input logic side, input logic is_write, input logic [7:0] rdata,
                             input int lat, input logic drop);
      exp_t e;
      e.side = side; e.is_write = is_write; e.rdata = rdata; e.lat = 8'(lat); e.drop = drop;
      sb.push_back(e);
   endtask

   // Apply reset to both instances and check the observed one comes up clean.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      i_lock = 1'b0; d_lock = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check({tag, "_bus_use"},   m_bus_use,   0);
      check({tag, "_bus_read"},  m_bus_read,  0);
      check({tag, "_bus_write"}, m_bus_write, 0);
      check({tag, "_bus_addr"},  m_bus_addr,  0);
      check({tag, "_dones"},     {m_i_done, m_d_done}, 0);
      check({tag, "_rdata"},     {m_i_rdata, m_d_rdata}, 0);
   endtask

   // Step cycles until every scoreboard entry has completed (bounded), checking
   // each completion's side, data and latency plus the strobe totals.
   task automatic run(input string tag, input int exp_reads, input int exp_writes,
                      input logic [31:0] exp_waddr, input logic [7:0] exp_wdata,
                      input bit idle_chk);
      int c = 0;
      int nrd = 0;
      int nwr = 0;
      logic [31:0] wa = '0;
      logic [7:0]  wd = '0;
      exp_t e;
      while (sb.size() > 0 && c < 40) begin
         @(negedge clk);
         if (m_bus_read && m_bus_write) check({tag, "_strobe_excl"}, 1, 0);
         if (m_bus_read) nrd++;
         if (m_bus_write) begin
            nwr++;
            wa = m_bus_addr;
            wd = m_bus_wdata;
         end
         if (m_i_done || m_d_done) begin
            check({tag, "_one_done"}, {m_i_done, m_d_done} == 2'b11, 0);
            e = sb.pop_front();
            check({tag, "_side"}, m_d_done, e.side);
            if (!e.is_write) check({tag, "_rdata"}, e.side ? m_d_rdata : m_i_rdata, e.rdata);
            check({tag, "_lat"}, c, e.lat);
            if (e.drop) begin
               if (e.side) d_req = 1'b0;
               else        i_req = 1'b0;
            end
         end
         c++;
      end
      check({tag, "_pending"}, sb.size(), 0);
      sb.delete();
      check({tag, "_reads"},  nrd, exp_reads);
      check({tag, "_writes"}, nwr, exp_writes);
      if (exp_writes > 0) begin
         check({tag, "_waddr"}, wa, exp_waddr);
         check({tag, "_wdata"}, wd, exp_wdata);
      end
      if (idle_chk) begin
         repeat (3) begin
            @(negedge clk);
            check({tag, "_idle"}, {m_bus_use, m_i_done, m_d_done}, 0);
         end
      end
   endtask

   initial begin
      // Reset state on the READ_LAT=1 instance.
      sel = 1'b0;
      do_reset("rst");

      // 1: I read of 0x10 returns 0x30 three cycles after the request.
      @(posedge clk); #1;
      i_addr = 32'h10; i_req = 1'b1;
      expect_txn(1'b0, 1'b0, 8'h30, 3, 1'b1);
      run("t1", 1, 0, 32'h0, 8'h0, 1'b1);

      // 2: D write of 0xA5 to 0xF004, one write strobe, done two cycles after request.
      @(posedge clk); #1;
      d_addr = 32'hF004; d_wdata = 8'hA5; d_write = 1'b1; d_req = 1'b1;
      expect_txn(1'b1, 1'b1, 8'h00, 2, 1'b1);
      run("t2", 0, 1, 32'hF004, 8'hA5, 1'b1);
      d_write = 1'b0;

      // 3: simultaneous requests straight after reset, both held: D, I, D, I.
      do_reset("rst3");
      @(posedge clk); #1;
      i_addr = 32'h40; d_addr = 32'h81; i_req = 1'b1; d_req = 1'b1;
      expect_txn(1'b1, 1'b0, 8'hA1, 3,  1'b0);
      expect_txn(1'b0, 1'b0, 8'h60, 6,  1'b0);
      expect_txn(1'b1, 1'b0, 8'hA1, 9,  1'b1);
      expect_txn(1'b0, 1'b0, 8'h60, 12, 1'b1);
      run("t3", 4, 0, 32'h0, 8'h0, 1'b1);

      // 4: READ_LAT=3 D read, three read-strobe cycles, done five cycles after request.
      sel = 1'b1;
      do_reset("rst4");
      @(posedge clk); #1;
      d_addr = 32'h1234; d_req = 1'b1;
      expect_txn(1'b1, 1'b0, 8'h54, 5, 1'b1);
      run("t4", 3, 0, 32'h0, 8'h0, 1'b1);

      // 5: reset during WAIT aborts the read; afterwards D again wins a tie.
      @(posedge clk); #1;
      d_addr = 32'h20; d_req = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_in_wait", m_bus_read, 1);
      reset_n = 1'b0;
      #1;
      check("t5_abort_use",  m_bus_use,  0);
      check("t5_abort_read", m_bus_read, 0);
      d_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t5_no_done_rst", {m_i_done, m_d_done}, 0);
      end
      check("t5_rdata_clear", m_d_rdata, 0);
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("t5_no_done_after", {m_bus_use, m_i_done, m_d_done}, 0);
      end
      @(posedge clk); #1;
      i_addr = 32'h05; d_addr = 32'h06; i_req = 1'b1; d_req = 1'b1;
      expect_txn(1'b1, 1'b0, 8'h26, 5,  1'b1);
      expect_txn(1'b0, 1'b0, 8'h25, 10, 1'b1);
      run("t5", 6, 0, 32'h0, 8'h0, 1'b1);

`ifdef MEM_ARB_LOCK_EN
      // 6: locked six-byte I burst while D requests throughout; D only after the burst.
      sel = 1'b0;
      do_reset("rst6");
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         i_addr = 32'h100 + 32'(k); i_lock = (k < 5); i_req = 1'b1;
         if (k == 0) begin
            expect_txn(1'b0, 1'b0, 8'h20, 3, 1'b1);
            @(posedge clk); #1;
            d_addr = 32'h200; d_req = 1'b1;
            sb.delete();
            expect_txn(1'b0, 1'b0, 8'h20, 2, 1'b1);
         end else begin
            expect_txn(1'b0, 1'b0, 8'(8'h20 + k), 3, 1'b1);
         end
         run("t6_burst", 1, 0, 32'h0, 8'h0, k < 5);
      end
      i_lock = 1'b0;
      expect_txn(1'b1, 1'b0, 8'h20, 2, 1'b1);
      run("t6_d_after", 1, 0, 32'h0, 8'h0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
